game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_game_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// game_sequencer: frame-synchronous START/PLAY/DYING/OVER controller for the dinosaur game.
// Transitions are decided on the frame_tick cycle and take effect on the following edge.
module game_sequencer #(
  parameter int H_LAST       = 639,
  parameter int V_LAST       = 479,
  parameter int DEATH_FRAMES = 60,
  parameter int LEVEL_FRAMES = 600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] vaddress,
  input  logic [9:0] haddress,
  input  logic       button,
  input  logic       debug,
  input  logic       hit,
  output logic [1:0] game_state,
  output logic       halt,
  output logic       game_rst,
  output logic       death_show,
  output logic [2:0] speed_level,
  output logic       frame_tick
);

  localparam int DW = $clog2(DEATH_FRAMES + 1);
  localparam int LW = $clog2(LEVEL_FRAMES + 1);
  localparam logic [DW-1:0] DEATH_LAST = DW'(DEATH_FRAMES - 1);
  localparam logic [LW-1:0] LVL_LAST   = LW'(LEVEL_FRAMES - 1);
  localparam logic [9:0]    H_END      = 10'(H_LAST);
  localparam logic [9:0]    V_END      = 10'(V_LAST);

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_PLAY  = 2'd1,
    S_OVER  = 2'd2,
    S_DYING = 2'd3
  } state_t;

  logic          r_btn_s1;
  logic          r_btn_s2;
  logic          r_btn_d;
  logic          r_dbg_s1;
  logic          r_dbg_s2;
  logic          r_frame_tick;
  logic          r_press_lat;
  logic          r_hit_lat;
  state_t        r_state;
  logic          r_halt;
  logic          r_game_rst;
  logic          r_death_show;
  logic [DW-1:0] r_death_cnt;
  logic [LW-1:0] r_lvl_cnt;
  logic [2:0]    r_speed;

  logic          w_eol;
  logic          w_press;
  logic          w_hit;
  state_t        w_next_state;
  logic          w_enter_play;
  logic [DW-1:0] w_death_cnt_nxt;
  logic [LW-1:0] w_lvl_cnt_nxt;
  logic [2:0]    w_speed_nxt;

  // Two-flop synchronizers; r_btn_d is the previous synchronized level for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_s1 <= 1'b0;
      r_btn_s2 <= 1'b0;
      r_btn_d  <= 1'b0;
      r_dbg_s1 <= 1'b0;
      r_dbg_s2 <= 1'b0;
    end else begin
      r_btn_s1 <= button;
      r_btn_s2 <= r_btn_s1;
      r_btn_d  <= r_btn_s2;
      r_dbg_s1 <= debug;
      r_dbg_s2 <= r_dbg_s1;
    end
  end

  assign w_eol   = (vaddress == V_END) && (haddress == H_END);
  assign w_press = r_btn_s2 & ~r_btn_d;
  assign w_hit   = hit & (r_state == S_PLAY);

  // End-of-frame strobe and per-frame event latches; a new event wins over the tick clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_tick <= 1'b0;
      r_press_lat  <= 1'b0;
      r_hit_lat    <= 1'b0;
    end else begin
      r_frame_tick <= w_eol;
      if (w_press) begin
        r_press_lat <= 1'b1;
      end else if (r_frame_tick) begin
        r_press_lat <= 1'b0;
      end else begin
        r_press_lat <= r_press_lat;
      end
      if (w_hit) begin
        r_hit_lat <= 1'b1;
      end else if (r_frame_tick) begin
        r_hit_lat <= 1'b0;
      end else begin
        r_hit_lat <= r_hit_lat;
      end
    end
  end

  // Next-state decision, only on the frame_tick cycle
  always_comb begin
    w_next_state    = r_state;
    w_enter_play    = 1'b0;
    w_death_cnt_nxt = r_death_cnt;
    if (r_frame_tick) begin
      case (r_state)
        S_START: begin
          if (r_press_lat) begin
            w_next_state = S_PLAY;
            w_enter_play = 1'b1;
          end else begin
            w_next_state = S_START;
          end
        end
        S_PLAY: begin
          // a hit on the tick cycle itself still belongs to the frame now ending
          if (r_hit_lat || w_hit) begin
            w_next_state    = S_DYING;
            w_death_cnt_nxt = {DW{1'b0}};
          end else begin
            w_next_state = S_PLAY;
          end
        end
        S_DYING: begin
          w_death_cnt_nxt = r_death_cnt + DW'(1);
          if (r_death_cnt == DEATH_LAST) begin
            w_next_state = S_OVER;
          end else begin
            w_next_state = S_DYING;
          end
        end
        S_OVER: begin
          if (r_dbg_s2) begin
            w_next_state = S_START;
          end else if (r_press_lat) begin
            w_next_state = S_PLAY;
            w_enter_play = 1'b1;
          end else begin
            w_next_state = S_OVER;
          end
        end
        default: begin
          w_next_state = S_START;
        end
      endcase
    end else begin
      w_next_state = r_state;
    end
  end

  // Level counter and saturating speed level; cleared on restart, advanced only in PLAY
  always_comb begin
    w_lvl_cnt_nxt = r_lvl_cnt;
    w_speed_nxt   = r_speed;
    if (w_enter_play) begin
      w_lvl_cnt_nxt = {LW{1'b0}};
      w_speed_nxt   = 3'd0;
    end else if (r_frame_tick && (r_state == S_PLAY)) begin
      if (r_lvl_cnt == LVL_LAST) begin
        w_lvl_cnt_nxt = {LW{1'b0}};
        if (r_speed != 3'd7) begin
          w_speed_nxt = r_speed + 3'd1;
        end else begin
          w_speed_nxt = r_speed;
        end
      end else begin
        w_lvl_cnt_nxt = r_lvl_cnt + LW'(1);
      end
    end else begin
      w_lvl_cnt_nxt = r_lvl_cnt;
      w_speed_nxt   = r_speed;
    end
  end

  // State register with outputs registered from the next state so they move together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_START;
      r_halt       <= 1'b0;
      r_death_show <= 1'b0;
      r_game_rst   <= 1'b0;
      r_death_cnt  <= {DW{1'b0}};
      r_lvl_cnt    <= {LW{1'b0}};
      r_speed      <= 3'd0;
    end else begin
      r_state      <= w_next_state;
      r_halt       <= (w_next_state == S_DYING) || (w_next_state == S_OVER);
      r_death_show <= (w_next_state == S_DYING);
      r_game_rst   <= w_enter_play;
      r_death_cnt  <= w_death_cnt_nxt;
      r_lvl_cnt    <= w_lvl_cnt_nxt;
      r_speed      <= w_speed_nxt;
    end
  end

  assign game_state  = r_state;
  assign halt        = r_halt;
  assign death_show  = r_death_show;
  assign game_rst    = r_game_rst;
  assign speed_level = r_speed;
  assign frame_tick  = r_frame_tick;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: a frame-level reference model queues the expected
// outputs at each frame end and a negedge monitor compares them when the DUT ticks.
module tb_game_sequencer;

  localparam int HL = 15;
  localparam int VL = 7;
  localparam int HT = 20;
  localparam int VT = 10;
  localparam int DF = 3;
  localparam int LF = 4;
  localparam int FL = HT * VT;
  localparam int K0 = VL * HT + HL + 2;  // raster index of the cycle after frame_tick

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] vaddress = 10'd0;
  logic [9:0] haddress = 10'd0;
  logic       button = 1'b0;
  logic       debug = 1'b0;
  logic       hit = 1'b0;
  logic [1:0] game_state;
  logic       halt;
  logic       game_rst;
  logic       death_show;
  logic [2:0] speed_level;
  logic       frame_tick;

  game_sequencer #(
    .H_LAST(HL), .V_LAST(VL), .DEATH_FRAMES(DF), .LEVEL_FRAMES(LF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vaddress(vaddress), .haddress(haddress),
    .button(button), .debug(debug), .hit(hit),
    .game_state(game_state), .halt(halt), .game_rst(game_rst),
    .death_show(death_show), .speed_level(speed_level), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] st;
    logic       hlt;
    logic       dsh;
    logic [2:0] spd;
    logic       grst;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // reference model: game phase plus frames spent playing / dying since the relevant entry
  int   m_state = 0;
  int   m_play = 0;
  int   m_dying = 0;
  bit   f_press = 1'b0;
  bit   f_hit = 1'b0;

  bit   mon_tick_seen = 1'b0;
  bit   mon_prev_last = 1'b0;
  exp_t mon_cur = '0;

  task automatic chk(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, int'(game_state), 0);
    chk({tag, "_halt"}, int'(halt), 0);
    chk({tag, "_game_rst"}, int'(game_rst), 0);
    chk({tag, "_death_show"}, int'(death_show), 0);
    chk({tag, "_speed"}, int'(speed_level), 0);
    chk({tag, "_frame_tick"}, int'(frame_tick), 0);
  endtask

  task automatic model_reset();
    m_state = 0;
    m_play  = 0;
    m_dying = 0;
    f_press = 1'b0;
    f_hit   = 1'b0;
    sb_q.delete();
  endtask

  task automatic model_frame_end();
    exp_t e;
    bit   grst;
    int   spd;
    grst = 1'b0;
    case (m_state)
      0: if (f_press) begin m_state = 1; m_play = 0; grst = 1'b1; end
      1: begin
        m_play++;
        if (f_hit) begin m_state = 3; m_dying = 0; end
      end
      3: begin
        m_dying++;
        if (m_dying == DF) m_state = 2;
      end
      2: begin
        if (debug) m_state = 0;
        else if (f_press) begin m_state = 1; m_play = 0; grst = 1'b1; end
      end
      default: m_state = 0;
    endcase
    spd    = (m_play / LF > 7) ? 7 : m_play / LF;
    e.st   = 2'(m_state);
    e.hlt  = (m_state == 2) || (m_state == 3);
    e.dsh  = (m_state == 3);
    e.spd  = 3'(spd);
    e.grst = grst;
    sb_q.push_back(e);
    f_press = 1'b0;
    f_hit   = 1'b0;
  endtask

  task automatic set_btn(input bit lvl);
    if (lvl && !button) f_press = 1'b1;
    button = lvl;
  endtask

  // one frame: from the cycle after frame_tick through the frame_tick cycle
  task automatic run_frame(input int pa, input bit ba, input int pb, input bit bb,
                           input int ph, input bit hh, input bit dbg,
                           input int rst_at, input int rel_at);
    for (int k = 0; k < FL; k++) begin
      int idx;
      @(posedge clk);
      #1;
      idx      = (K0 + k) % FL;
      vaddress = 10'(idx / HT);
      haddress = 10'(idx % HT);
      if (k == 0) debug = dbg;
      if (k == rst_at) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_reset_outputs("async_rst");
      end
      if (k == rel_at) begin
        rst_n = 1'b1;
        if (button) f_press = 1'b1;
      end
      if (k == pa) set_btn(ba);
      if (k == pb) set_btn(bb);
      hit = hh || (k == ph);
      if (hit && rst_n && m_state == 1) f_hit = 1'b1;
      if (k == FL - 1 && rst_n) model_frame_end();
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_frame(-1, 1'b0, -1, 1'b0, -1, 1'b0, 1'b0, -1, -1);
  endtask

  // monitor: checks frame_tick timing every cycle and pops an expectation after each tick
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk_reset_outputs("in_reset");
        mon_cur       = '0;
        mon_tick_seen = 1'b0;
        mon_prev_last = 1'b0;
      end else begin
        chk("frame_tick", int'(frame_tick), int'(mon_prev_last));
        if (mon_tick_seen) begin
          chk("scoreboard_entry", int'(sb_q.size() > 0), 1);
          if (sb_q.size() > 0) begin
            e       = sb_q.pop_front();
            mon_cur = e;
            chk("game_rst_pulse", int'(game_rst), int'(e.grst));
          end
        end else begin
          chk("game_rst_idle", int'(game_rst), 0);
        end
        chk("game_state", int'(game_state), int'(mon_cur.st));
        chk("halt", int'(halt), int'(mon_cur.hlt));
        chk("death_show", int'(death_show), int'(mon_cur.dsh));
        chk("speed_level", int'(speed_level), int'(mon_cur.spd));
        mon_tick_seen = frame_tick;
        mon_prev_last = (vaddress == 10'(VL)) && (haddress == 10'(HL));
      end
    end
  end

  initial begin
    #2;
    chk_reset_outputs("power_on");
    run_frame(-1, 1'b0, -1, 1'b0, -1, 1'b0, 1'b0, -1, 10);
    idle(1);
    // press -> PLAY with one-cycle game_rst
    run_frame(50, 1'b1, 120, 1'b0, -1, 1'b0, 1'b0, -1, -1);
    idle(2);
    // mid-frame hit -> DYING, press while dying ignored, then OVER
    run_frame(-1, 1'b0, -1, 1'b0, 90, 1'b0, 1'b0, -1, -1);
    run_frame(40, 1'b1, 100, 1'b0, -1, 1'b0, 1'b0, -1, -1);
    idle(3);
    // debug and press in the same OVER frame -> START, no game_rst
    run_frame(50, 1'b1, 120, 1'b0, -1, 1'b0, 1'b1, -1, -1);
    idle(1);
    // held button: one START->PLAY, hit on the tick cycle, no OVER->PLAY while held
    run_frame(50, 1'b1, -1, 1'b0, -1, 1'b0, 1'b0, -1, -1);
    run_frame(-1, 1'b0, -1, 1'b0, FL - 1, 1'b0, 1'b0, -1, -1);
    idle(5);
    run_frame(40, 1'b0, 120, 1'b1, -1, 1'b0, 1'b0, -1, -1);
    // speed saturation over 33 PLAY frames, then restart clears it
    idle(33);
    run_frame(30, 1'b0, -1, 1'b0, 90, 1'b0, 1'b0, -1, -1);
    idle(3);
    run_frame(50, 1'b1, 120, 1'b0, -1, 1'b0, 1'b0, -1, -1);
    // reset while dying with hit held; no transition after release until a press
    run_frame(-1, 1'b0, -1, 1'b0, 90, 1'b0, 1'b0, -1, -1);
    run_frame(-1, 1'b0, -1, 1'b0, -1, 1'b1, 1'b0, 60, 120);
    idle(2);
    run_frame(50, 1'b1, 120, 1'b0, -1, 1'b0, 1'b0, -1, -1);
    // randomized frames
    for (int i = 0; i < 40; i++) begin
      int pa, pb, ph;
      bit ba, bb, dbg;
      pa  = int'($urandom_range(20, 90));
      pb  = int'($urandom_range(100, 180));
      ba  = 1'($urandom % 2);
      bb  = 1'($urandom % 2);
      dbg = ($urandom % 5) == 0;
      if (($urandom % 3) == 0) ph = (($urandom % 3) == 0) ? FL - 1 : int'($urandom_range(20, 180));
      else ph = -1;
      run_frame(pa, ba, pb, bb, ph, 1'b0, dbg, -1, -1);
    end
    repeat (5) @(posedge clk);
    chk("queue_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
